warmer_xfade_ctrl: RTL and testbench
====================================

WARMER_XFADE_CTRL -- requirements
Module: warmer_xfade_ctrl

Interface
REQ-001 Parameter FADE_SHIFT, default 8: crossfade length is 2^FADE_SHIFT sample ticks; legal range 1..12.
REQ-002 Parameter PRIME_SAMPLES, default 2: sample ticks the warmer runs before the fade-in starts; legal range 1..15.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sample_valid  input  1  one-cycle strobe marking a new audio sample (sample tick).
REQ-006 dry_sample  input  16 signed  unprocessed sample, valid with sample_valid.
REQ-007 wet_sample  input  16 signed  warmer output, valid with sample_valid.
REQ-008 engage_req  input  1  level: 1 = effect wanted, 0 = bypass wanted.
REQ-009 warmer_enable  output  1  drives the warmer's enable input.
REQ-010 mix_sample  output  16 signed  crossfaded output sample.
REQ-011 mix_valid  output  1  one-cycle strobe, mix_sample is new.
REQ-012 gain  output  FADE_SHIFT+1  current wet gain, 0..2^FADE_SHIFT.
REQ-013 busy  output  1  high in PRIME, FADE_IN and FADE_OUT.

Function
REQ-014 FSM states: BYPASS, PRIME, FADE_IN, ACTIVE, FADE_OUT. State and gain change only on cycles with sample_valid=1.
REQ-015 BYPASS: gain=0, warmer_enable=0. On a tick with engage_req=1, go to PRIME and clear the prime counter.
REQ-016 PRIME: warmer_enable=1, gain held at 0, prime counter +1 per tick. After PRIME_SAMPLES ticks, go to FADE_IN. A tick with engage_req=0 returns to BYPASS.
REQ-017 FADE_IN: gain +1 per tick. When gain reaches 2^FADE_SHIFT, go to ACTIVE. A tick with engage_req=0 goes to FADE_OUT without a gain step.
REQ-018 ACTIVE: gain=2^FADE_SHIFT. A tick with engage_req=0 goes to FADE_OUT.
REQ-019 FADE_OUT: gain -1 per tick. When gain reaches 0, go to BYPASS. A tick with engage_req=1 goes to FADE_IN without a gain step.
REQ-020 warmer_enable is 1 in PRIME, FADE_IN, ACTIVE and FADE_OUT. It is registered and changes on the same edge as the state.
REQ-021 Mix uses the gain held before that tick's update: mix = (wet*g + dry*(2^FADE_SHIFT - g)) >>> FADE_SHIFT.
REQ-022 Products are 32-bit signed. The sum is 33-bit signed. The shift is arithmetic (floor). The result is hard-clamped to [-32768, 32767], no fold.
REQ-023 Latency: mix_sample and mix_valid update on the edge that samples sample_valid=1 (one cycle). mix_sample holds between ticks.
REQ-024 engage_req changes between ticks are ignored. Only the value present at a tick matters.
REQ-025 sample_valid on consecutive cycles is legal; each cycle counts as one tick.

Reset
REQ-026 While rst_n=0: state=BYPASS, gain=0, prime counter=0, warmer_enable=0, mix_sample=0, mix_valid=0, busy=0.
REQ-027 Reset asserted mid-fade forces the values in REQ-026 immediately. After release, operation restarts from BYPASS with no residual gain.
REQ-028 The first tick after reset release is processed normally.

Structure
REQ-029 Shared package holds the state enum, the FADE_SHIFT and PRIME_SAMPLES defaults, and the 16-bit sample limits SAMPLE_MAX and SAMPLE_MIN.
REQ-030 The multiply/add/shift/clamp path is one sub-module, xfade_mix, fully combinational. The FSM and output registers stay in warmer_xfade_ctrl.

Verification
REQ-031 All scenarios run with FADE_SHIFT=2 and PRIME_SAMPLES=2.
REQ-032 Engage scenario: dry=1000, wet=-1000, engage_req=1 from BYPASS. Required: warmer_enable rises on tick 1. Mix sequence is 1000, 1000, 1000, 500, 0, -500, -1000, then steady -1000. ACTIVE is reached with gain=4.
REQ-033 Abort mid-fade scenario: engage_req drops while in FADE_IN at gain=2. Required: FADE_OUT on that tick with gain 2, then 1, then 0, then BYPASS with warmer_enable=0.
REQ-034 Clamp and rounding scenario: dry=32767, wet=-32768 at gain=1. Required: mix=16383. Also dry=-1, wet=-1, any gain: required mix=-1.
REQ-035 Reset mid-operation scenario: rst_n pulled low asynchronously (not on a clock edge) during FADE_OUT. Required: all outputs zero before the next clk edge. After release, BYPASS with mix equal to dry.
REQ-036 Strobe-gating scenario: engage_req toggles 1→0 between ticks, and sample_valid is asserted on back-to-back cycles. Required: no state change without a tick, and one gain step per valid cycle.

Source files
------------

// File: rtl/warmer_xfade_ctrl_pkg.sv
// Shared types and constants for the warmer crossfade controller.
// Holds the FSM state enum, parameter defaults and 16-bit sample limits.
package warmer_xfade_ctrl_pkg;

  localparam int unsigned DEFAULT_FADE_SHIFT    = 8;
  localparam int unsigned DEFAULT_PRIME_SAMPLES = 2;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  typedef enum logic [2:0] {
    StBypass,
    StPrime,
    StFadeIn,
    StActive,
    StFadeOut
  } state_e;

endpackage

// File: rtl/warmer_xfade_ctrl_if.sv
// Sample stream, engage request and status signals of the crossfade controller.
// The slave modport is the controller's view; master is the surrounding audio path.
interface warmer_xfade_ctrl_if
  import warmer_xfade_ctrl_pkg::*;
#(
  parameter int unsigned FADE_SHIFT = DEFAULT_FADE_SHIFT
);

  logic                     sample_valid;
  logic signed [15:0]       dry_sample;
  logic signed [15:0]       wet_sample;
  logic                     engage_req;
  logic                     warmer_enable;
  logic signed [15:0]       mix_sample;
  logic                     mix_valid;
  logic [FADE_SHIFT:0]      gain;
  logic                     busy;

  modport master (
    output sample_valid, dry_sample, wet_sample, engage_req,
    input  warmer_enable, mix_sample, mix_valid, gain, busy
  );

  modport slave (
    input  sample_valid, dry_sample, wet_sample, engage_req,
    output warmer_enable, mix_sample, mix_valid, gain, busy
  );

endinterface

// File: rtl/warmer_xfade_ctrl_mix.sv
// Combinational crossfade datapath: weighted sum of wet and dry, floor shift, clamp.
module xfade_mix
  import warmer_xfade_ctrl_pkg::*;
#(
  parameter int unsigned FADE_SHIFT = DEFAULT_FADE_SHIFT
) (
  input  logic signed [15:0] dry,
  input  logic signed [15:0] wet,
  input  logic [FADE_SHIFT:0] gain,
  output logic signed [15:0] mix
);

  localparam logic signed [31:0] Unity = 32'sd1 <<< FADE_SHIFT;

  logic signed [31:0] g_wet;
  logic signed [31:0] g_dry;
  logic signed [31:0] wet_prod;
  logic signed [31:0] dry_prod;
  logic signed [32:0] sum;
  logic signed [32:0] shifted;

  always_comb begin
    g_wet    = signed'(32'(gain));
    g_dry    = Unity - g_wet;
    wet_prod = 32'(wet) * g_wet;
    dry_prod = 32'(dry) * g_dry;
    sum      = 33'(wet_prod) + 33'(dry_prod);
    shifted  = sum >>> FADE_SHIFT;
    // Weights always sum to unity, so the clamp is a guard rather than a normal path.
    if (shifted > 33'(SAMPLE_MAX)) begin
      mix = 16'(SAMPLE_MAX);
    end else if (shifted < 33'(SAMPLE_MIN)) begin
      mix = 16'(SAMPLE_MIN);
    end else begin
      mix = 16'(shifted);
    end
  end

endmodule

// File: rtl/warmer_xfade_ctrl.sv
// Engage/bypass controller for the warmer: primes the effect, then crossfades
// between dry and wet on sample ticks. All state advances only on sample_valid.
module warmer_xfade_ctrl
  import warmer_xfade_ctrl_pkg::*;
#(
  parameter int unsigned FADE_SHIFT    = DEFAULT_FADE_SHIFT,
  parameter int unsigned PRIME_SAMPLES = DEFAULT_PRIME_SAMPLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  warmer_xfade_ctrl_if.slave      bus
);

  localparam logic [FADE_SHIFT:0] GainMax = (FADE_SHIFT + 1)'(1) << FADE_SHIFT;
  localparam logic [FADE_SHIFT:0] GainOne = (FADE_SHIFT + 1)'(1);
  // The engage tick counts as the first prime sample; PRIME lasts at least one tick.
  localparam logic [3:0] PrimeLast = (PRIME_SAMPLES > 1) ? 4'(PRIME_SAMPLES - 1) : 4'd1;

  state_e              state_q, state_d;
  logic [FADE_SHIFT:0] gain_q, gain_d;
  logic [3:0]          prime_q, prime_d;
  logic                enable_q, enable_d;
  logic signed [15:0]  mix_q, mix_d;
  logic                mix_valid_q;
  logic signed [15:0]  mix_w;

  xfade_mix #(
    .FADE_SHIFT(FADE_SHIFT)
  ) u_mix (
    .dry  (bus.dry_sample),
    .wet  (bus.wet_sample),
    .gain (gain_q),
    .mix  (mix_w)
  );

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    prime_d = prime_q;
    if (bus.sample_valid) begin
      unique case (state_q)
        StBypass: begin
          gain_d = '0;
          if (bus.engage_req) begin
            state_d = StPrime;
            prime_d = '0;
          end
        end
        StPrime: begin
          if (!bus.engage_req) begin
            state_d = StBypass;
            prime_d = '0;
          end else begin
            prime_d = prime_q + 4'd1;
            if (prime_d >= PrimeLast) state_d = StFadeIn;
          end
        end
        StFadeIn: begin
          if (!bus.engage_req) begin
            state_d = StFadeOut;
          end else if (gain_q >= GainMax - GainOne) begin
            gain_d  = GainMax;
            state_d = StActive;
          end else begin
            gain_d = gain_q + GainOne;
          end
        end
        StActive: begin
          if (!bus.engage_req) state_d = StFadeOut;
        end
        StFadeOut: begin
          if (bus.engage_req) begin
            // Reversing at full gain has nothing left to fade in.
            state_d = (gain_q == GainMax) ? StActive : StFadeIn;
          end else if (gain_q <= GainOne) begin
            gain_d  = '0;
            state_d = StBypass;
            prime_d = '0;
          end else begin
            gain_d = gain_q - GainOne;
          end
        end
        default: begin
          state_d = StBypass;
          gain_d  = '0;
          prime_d = '0;
        end
      endcase
    end
    enable_d = (state_d != StBypass);
    mix_d    = bus.sample_valid ? mix_w : mix_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBypass;
      gain_q      <= '0;
      prime_q     <= '0;
      enable_q    <= 1'b0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      prime_q     <= prime_d;
      enable_q    <= enable_d;
      mix_q       <= mix_d;
      mix_valid_q <= bus.sample_valid;
    end
  end

  assign bus.warmer_enable = enable_q;
  assign bus.mix_sample    = mix_q;
  assign bus.mix_valid     = mix_valid_q;
  assign bus.gain          = gain_q;
  assign bus.busy          = (state_q == StPrime) || (state_q == StFadeIn) ||
                             (state_q == StFadeOut);

endmodule

// File: tb/tb_warmer_xfade_ctrl.sv
// Self-checking bench for warmer_xfade_ctrl: directed scenarios plus randomized
// ticks compared against a behavioural gain/mix model.
module tb_warmer_xfade_ctrl;
  import warmer_xfade_ctrl_pkg::*;

  localparam int FS        = 2;
  localparam int PS        = 2;
  localparam int N         = 1 << FS;
  localparam int PRIME_LEN = (PS < 2) ? 2 : PS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  warmer_xfade_ctrl_if #(.FADE_SHIFT(FS)) bus ();

  warmer_xfade_ctrl #(
    .FADE_SHIFT   (FS),
    .PRIME_SAMPLES(PS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: enabled flag, ticks primed so far, fade direction, gain.
  bit m_en, m_up, m_valid;
  int m_pc, m_g, m_mix;

  function automatic int mix_ref(input int d, input int w, input int g);
    longint s, q;
    s = longint'(w) * g + longint'(d) * (N - g);
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic bit m_busy();
    return m_en && !(m_up && m_g == N);
  endfunction

  task automatic model_reset();
    m_en = 0; m_up = 0; m_valid = 0; m_pc = 0; m_g = 0; m_mix = 0;
  endtask

  task automatic model_tick(input bit e, input int d, input int w);
    m_mix = mix_ref(d, w, m_g);
    if (!m_en) begin
      if (e) begin m_en = 1; m_pc = 1; m_up = 1; end
    end else if (m_pc < PRIME_LEN) begin
      if (!e) begin m_en = 0; m_pc = 0; end
      else m_pc++;
    end else if (e != m_up) begin
      m_up = e;
    end else if (m_up) begin
      if (m_g < N) m_g++;
    end else begin
      m_g = (m_g > 0) ? m_g - 1 : 0;
      if (m_g == 0) begin m_en = 0; m_pc = 0; end
    end
  endtask

  task automatic step(input bit v, input bit e, input int d, input int w);
    @(negedge clk);
    bus.sample_valid = v;
    bus.engage_req   = e;
    bus.dry_sample   = 16'(d);
    bus.wet_sample   = 16'(w);
    @(posedge clk);
    #1;
    m_valid = v;
    if (v) model_tick(e, d, w);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic go_bypass();
    int guard = 0;
    while ((m_en || bus.warmer_enable) && guard < 20) begin
      step(1, 0, rnd_sample(), rnd_sample());
      guard++;
    end
    n_checks++;
    if (bus.warmer_enable !== 1'b0 || m_en) begin
      n_fail++;
      $display("FAIL go_bypass: warmer_enable=%0b after %0d ticks, required 0",
               bus.warmer_enable, guard);
    end
  endtask

  task automatic test_reset();
    bus.sample_valid = 0; bus.engage_req = 0; bus.dry_sample = '0; bus.wet_sample = '0;
    rst_n = 0;
    model_reset();
    #12;
    n_checks++;
    if (bus.gain !== '0 || bus.warmer_enable !== 1'b0 || bus.mix_sample !== '0 ||
        bus.mix_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: gain=%0d en=%0b mix=%0d valid=%0b busy=%0b, required all 0",
               bus.gain, bus.warmer_enable, bus.mix_sample, bus.mix_valid, bus.busy);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_engage();
    int exp_mix[9] = '{1000, 1000, 1000, 500, 0, -500, -1000, -1000, -1000};
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 1000, -1000);
      n_checks++;
      if (int'(bus.mix_sample) !== exp_mix[i] || int'(bus.mix_sample) !== m_mix) begin
        n_fail++;
        $display("FAIL engage_mix[%0d]: got %0d, required %0d", i, bus.mix_sample,
                 exp_mix[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (bus.warmer_enable !== 1'b1) begin
          n_fail++;
          $display("FAIL engage_enable: got %0b, required 1", bus.warmer_enable);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (int'(bus.gain) !== 4 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL engage_active: gain=%0d busy=%0b, required gain=4 busy=0",
                   bus.gain, bus.busy);
        end
      end
    end
  endtask

  task automatic test_abort();
    int exp_g[3] = '{2, 1, 0};
    bit exp_en[3] = '{1, 1, 0};
    go_bypass();
    repeat (4) step(1, 1, rnd_sample(), rnd_sample());
    n_checks++;
    if (int'(bus.gain) !== 2 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: gain=%0d busy=%0b, required gain=2 busy=1",
               bus.gain, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, rnd_sample(), rnd_sample());
      n_checks++;
      if (int'(bus.gain) !== exp_g[i] || bus.warmer_enable !== exp_en[i] ||
          bus.busy !== exp_en[i]) begin
        n_fail++;
        $display("FAIL abort[%0d]: gain=%0d en=%0b busy=%0b, required gain=%0d en=%0b",
                 i, bus.gain, bus.warmer_enable, bus.busy, exp_g[i], exp_en[i]);
      end
    end
  endtask

  task automatic test_clamp();
    go_bypass();
    repeat (3) step(1, 1, rnd_sample(), rnd_sample());
    n_checks++;
    if (int'(bus.gain) !== 1) begin
      n_fail++;
      $display("FAIL clamp_setup: gain=%0d, required 1", bus.gain);
    end
    step(1, 1, 32767, -32768);
    n_checks++;
    if (int'(bus.mix_sample) !== 16383) begin
      n_fail++;
      $display("FAIL clamp_extreme: mix=%0d, required 16383", bus.mix_sample);
    end
    for (int i = 0; i < 6; i++) begin
      step(1, (i < 4), -1, -1);
      n_checks++;
      if (int'(bus.mix_sample) !== -1) begin
        n_fail++;
        $display("FAIL floor_minus1[%0d]: mix=%0d, required -1", i, bus.mix_sample);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    go_bypass();
    repeat (6) step(1, 1, rnd_sample(), rnd_sample());
    repeat (2) step(1, 0, rnd_sample(), rnd_sample());
    n_checks++;
    if (bus.busy !== 1'b1 || int'(bus.gain) !== 3) begin
      n_fail++;
      $display("FAIL reset_mid_setup: gain=%0d busy=%0b, required gain=3 busy=1",
               bus.gain, bus.busy);
    end
    #3;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (bus.gain !== '0 || bus.warmer_enable !== 1'b0 || bus.mix_sample !== '0 ||
        bus.mix_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: gain=%0d en=%0b mix=%0d valid=%0b busy=%0b",
               bus.gain, bus.warmer_enable, bus.mix_sample, bus.mix_valid, bus.busy);
    end
    @(negedge clk);
    rst_n = 1;
    d = rnd_sample();
    step(1, 0, d, rnd_sample());
    n_checks++;
    if (int'(bus.mix_sample) !== d || bus.warmer_enable !== 1'b0 || bus.gain !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_after: mix=%0d en=%0b gain=%0d, required mix=%0d en=0 gain=0",
               bus.mix_sample, bus.warmer_enable, bus.gain, d);
    end
  endtask

  task automatic test_back_to_back();
    int exp_g[5] = '{2, 3, 4, 4, 3};
    bit e_seq[5] = '{1, 1, 1, 0, 0};
    go_bypass();
    repeat (3) step(1, 1, rnd_sample(), rnd_sample());
    step(0, 1, rnd_sample(), rnd_sample());
    step(0, 0, rnd_sample(), rnd_sample());
    n_checks++;
    if (int'(bus.gain) !== 1 || bus.mix_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_idle: gain=%0d valid=%0b busy=%0b, required gain=1 valid=0 busy=1",
               bus.gain, bus.mix_valid, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, e_seq[i], rnd_sample(), rnd_sample());
      n_checks++;
      if (int'(bus.gain) !== exp_g[i] || bus.mix_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: gain=%0d valid=%0b, required gain=%0d valid=1",
                 i, bus.gain, bus.mix_valid, exp_g[i]);
      end
    end
  endtask

  task automatic test_random();
    bit e = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) e = ~e;
      step(($urandom_range(0, 2) != 0), e, rnd_sample(), rnd_sample());
      n_checks++;
      if (int'(bus.gain) !== m_g || int'(bus.mix_sample) !== m_mix ||
          bus.mix_valid !== m_valid || bus.warmer_enable !== m_en ||
          bus.busy !== m_busy()) begin
        n_fail++;
        $display("FAIL random[%0d]: gain=%0d mix=%0d valid=%0b en=%0b busy=%0b, %s%0d %0d %0b %0b %0b",
                 i, bus.gain, bus.mix_sample, bus.mix_valid, bus.warmer_enable, bus.busy,
                 "required ", m_g, m_mix, m_valid, m_en, m_busy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_engage();
    test_abort();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
